// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: DATA_BITS/PARITY/STOP_BITS framing, start-glitch rejection,
// valid/ready output holding register, and frame/parity error, overrun and break reporting.
module uart_rx_cfg #(
    parameter int SYSTEM_CLOCK  = 32000000,
    parameter int BAUD_RATE     = 9600,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1,
    parameter int CYC_COUNT     = SYSTEM_CLOCK / BAUD_RATE,
    parameter int CYC_HALFCOUNT = CYC_COUNT / 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 din,
    input  logic                 ready,
    output logic                 valid,
    output logic [DATA_BITS-1:0] data_rx,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 break_det
);

    localparam int CW = $clog2(CYC_COUNT) + 1;
    localparam int BW = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_WAIT_HIGH
    } state_t;

    state_t               state;
    logic                 sync1;
    logic                 rxs;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err_r;
    logic                 par_zero;
    logic                 stop_err_r;
    logic                 stop_first0;

    logic bit_tick;
    logic last_stop;
    logic frame_ferr;
    logic is_break;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= din;
            rxs   <= sync1;
        end
    end

    // With one stop bit the first stop sample is the one being taken right now.
    assign bit_tick   = (cnt == CW'(CYC_COUNT - 1));
    assign last_stop  = (state == S_STOP) && bit_tick && (bit_idx == BW'(STOP_BITS - 1));
    assign frame_ferr = stop_err_r | ~rxs;
    assign is_break   = (shreg == '0) && par_zero &&
                        ((STOP_BITS == 1) ? ~rxs : stop_first0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            par_err_r   <= 1'b0;
            par_zero    <= 1'b1;
            stop_err_r  <= 1'b0;
            stop_first0 <= 1'b0;
            valid       <= 1'b0;
            data_rx     <= '0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            break_det   <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            break_det <= 1'b0;
            if (valid && ready)
                valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    cnt         <= '0;
                    bit_idx     <= '0;
                    par_err_r   <= 1'b0;
                    par_zero    <= 1'b1;
                    stop_err_r  <= 1'b0;
                    stop_first0 <= 1'b0;
                    if (!rxs)
                        state <= S_START;
                end
                S_START: begin
                    if (rxs) begin
                        state <= S_IDLE;
                    end else if (cnt == CW'(CYC_HALFCOUNT - 1)) begin
                        state <= S_DATA;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        cnt   <= '0;
                        shreg <= {rxs, shreg[DATA_BITS-1:1]};
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_PAR: begin
                    if (bit_tick) begin
                        cnt       <= '0;
                        par_zero  <= ~rxs;
                        par_err_r <= ((^shreg) ^ rxs) != (PARITY == 1);
                        state     <= S_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_tick) begin
                        cnt <= '0;
                        if (last_stop) begin
                            state <= frame_ferr ? S_WAIT_HIGH : S_IDLE;
                            // A break never occupies the holding register.
                            if (is_break) begin
                                break_det <= 1'b1;
                            end else if (!valid || ready) begin
                                valid      <= 1'b1;
                                data_rx    <= shreg;
                                parity_err <= par_err_r;
                                frame_err  <= frame_ferr;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            bit_idx     <= bit_idx + 1'b1;
                            stop_err_r  <= stop_err_r | ~rxs;
                            stop_first0 <= ~rxs;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxs)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver for the lab SoC serial path. It adds configurable data width, parity and stop bits to the fixed 8N1 receiver. It also provides input synchronisation, start-bit glitch rejection, a valid/ready output handshake, and error, overrun and break reporting. It sits between the external RX pin and any byte consumer, such as a FIFO or command decoder.

## Interface
- SYSTEM_CLOCK, 32000000: clk frequency in Hz.
- BAUD_RATE, 9600: line rate in baud.
- DATA_BITS, 8: data bits per frame. Legal range is 5..9.
- PARITY, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- CYC_COUNT, SYSTEM_CLOCK/BAUD_RATE: clock cycles per bit. Derived; must be ≥ 8.
- CYC_HALFCOUNT, CYC_COUNT/2: derived.
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  1  raw RX line. Asynchronous to clk; idles high.
- ready  in  1  consumer accepts the held frame.
- valid  out  1  a frame is held on the outputs.
- data_rx  out  DATA_BITS  received data. Bit 0 is the first bit received.
- parity_err  out  1  parity mismatch for the held frame. Forced 0 when PARITY=0.
- frame_err  out  1  at least one stop bit of the held frame sampled 0.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.
- break_det  out  1  one-cycle pulse when a break is detected.

## Operation
- din passes through a 2-flop synchroniser; both flops reset to 1. All logic below uses the synchronised value, called rxs.
- The bit counter is $clog2(CYC_COUNT)+1 bits wide.
- State machine:
  - IDLE → START when rxs=0.
  - START:
    - count cycles while rxs=0;
    - if rxs=1 before CYC_HALFCOUNT cycles elapse → IDLE (glitch rejected, no outputs change);
    - at CYC_HALFCOUNT → DATA, counter cleared.
  - DATA:
    - sample rxs every CYC_COUNT cycles;
    - shift right into the DATA_BITS shift register, LSB first;
    - after DATA_BITS samples → PARITY if PARITY≠0, else STOP.
  - PARITY:
    - one sample;
    - odd mode requires the XOR of data and parity bit to be 1; even mode requires it to be 0.
  - STOP:
    - STOP_BITS samples at CYC_COUNT spacing;
    - if any sample is 0, frame_err is set for this frame.
  - Frame completion:
    - with no frame_err → IDLE;
    - with frame_err → WAIT_HIGH, which stays until rxs=1 and then goes to IDLE.
- Break condition: all data samples are 0, the parity sample is 0 (when present) and the first stop sample is 0.
  - On a break: pulse break_det, do not assert valid, go to WAIT_HIGH.
- Handshake on frame completion, when there is no break:
  - If valid=0, or valid=1 and ready=1 in the same cycle: load data_rx, parity_err and frame_err, and set valid=1.
  - If valid=1 and ready=0: drop the new frame, pulse overrun, and keep the held values unchanged.
- While valid=1:
  - ready=1 clears valid on the next edge;
  - data_rx, parity_err and frame_err are stable.
- Frames with parity_err or frame_err are still delivered, with valid=1.
- Reception continues while valid=1; the receiver never stalls the line.

## Timing
- Reset values:
  - valid=0, data_rx=0, parity_err=0, frame_err=0, overrun=0, break_det=0;
  - state=IDLE, counters 0, synchroniser flops 1.
- Reset mid-frame aborts the frame immediately. After release, the receiver waits in IDLE for a fresh falling edge; a partial frame is never delivered.
- Input latency: 2 clk from din to rxs.
- Sample points, measured from the first rxs=0 cycle:
  - start bit is confirmed at cycle CYC_HALFCOUNT;
  - data bit k is sampled at CYC_HALFCOUNT + (k+1)·CYC_COUNT;
  - parity and stop bits follow at the same spacing.
- valid rises on the clock edge after the last stop-bit sample. overrun and break_det pulse at that same edge.
- valid/ready: data transfers on a cycle with valid=1 and ready=1. ready while valid=0 has no effect.
- The RX path tolerates ±2% baud mismatch over a 12-bit frame.

## Test plan
Configuration for all cases: SYSTEM_CLOCK=1600000, BAUD_RATE=100000, giving CYC_COUNT=16.
- 8N1 with ready=1, send 0xA5 → one valid cycle, data_rx=0xA5, parity_err=0, frame_err=0.
- PARITY=2, send 0x3C with a correct parity bit 0, then 0x3C with parity bit 1 → first frame parity_err=0, second frame parity_err=1; both valid.
- Drive din low for 5 cycles, then high → no state advance; valid, data_rx and all flags unchanged.
- ready=0, send 0x11 then 0x22 → valid=1, data_rx=0x11 held, and overrun pulses once at the end of the second frame.
- Hold din low for 2 frame times, then high → break_det pulses once, valid stays 0, then 0x55 is received normally.
- Send 0x0F and assert rst_n=0 during bit 3, release, then send 0x81 → no frame from the aborted transfer; data_rx=0x81 with valid.
